// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and width defaults
// for the bit-serial ALU responder.
package alu_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // SUB and SLT both run A + ~B + 1 through the slice
   function automatic logic is_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional B inversion, then
// logic op or full-adder sum selected by opcode.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [3:0] op,
   output logic       r,
   output logic       cout
);

   logic w_b;
   logic w_sum;

   assign w_b   = b ^ is_sub(op);
   assign w_sum = a ^ w_b ^ cin;
   assign cout  = (a & w_b) | (cin & (a ^ w_b));

   always_comb begin
      r = 1'b0;
      unique case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD:  r = w_sum;
         OP_SUB:  r = w_sum;
         OP_SLT:  r = w_sum;
         OP_NOR:  r = ~(a | b);
         OP_NAND: r = ~(a & b);
         default: r = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial handshaked ALU: one bit per cycle through
// alu_bit_slice, result and ZCV flags held until taken.
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_op;
   logic             r_carry;
   logic [WIDTH-2:0] r_shift;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_cout;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;

   logic             w_r;
   logic             w_cout;
   logic             w_ovf;
   logic             w_arith;
   logic             w_last;
   logic [WIDTH-1:0] w_final;

   alu_bit_slice u_slice (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .op   (r_op),
      .r    (w_r),
      .cout (w_cout)
   );

   // On the final edge r_carry is the carry into the MSB
   assign w_ovf   = r_carry ^ w_cout;
   assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
   assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_final = {w_r, r_shift};
      if (r_op == OP_SLT)
         w_final = {{(WIDTH-1){1'b0}}, w_r ^ w_ovf};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_carry     <= 1'b0;
         r_shift     <= '0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= src1;
                  r_b        <= src2;
                  r_op       <= ALU_control;
                  r_cnt      <= '0;
                  r_carry    <= is_sub(ALU_control);
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_cout;
               r_shift <= {w_r, r_shift[WIDTH-2:1]};
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result    <= w_final;
                  r_zero      <= (w_final == '0);
                  r_cout      <= w_arith & w_cout;
                  r_ovf       <= w_arith & w_ovf;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign cout      = r_cout;
   assign overflow  = r_ovf;

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Bit-serial, handshaked ALU responder: the consumer side of the operand/opcode/result/ZCV interface the lab ALU benches drive.
- Accepts one {src1, src2, ALU_control} request, computes one bit per cycle through a 1-bit slice, then returns result plus zero/cout/overflow.
- Sits between a pattern driver/checker and the datapath; an area-reduced alternative to the combinational ALU, with the same opcode set and flag semantics.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 5, bit-counter width; equals clog2(WIDTH).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  responder can accept a request.
- src1  in  WIDTH  operand A.
- src2  in  WIDTH  operand B.
- ALU_control  in  4  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.
- cout  out  1  carry out (ADD/SUB only).
- overflow  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A + ~B + 1), 0111 SLT (signed), 1100 NOR, 1101 NAND.
  - Any other opcode gives result 0, cout 0, overflow 0, zero 1.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, latch src1, src2 and opcode; cnt=0; carry = 1 for SUB/SLT, else 0; go to RUN.
  - RUN: each edge, the slice processes bit cnt. The result bit shifts into the result register from the MSB end; the carry register updates; cnt increments. At cnt==WIDTH-1 go to DONE.
  - DONE: out_valid=1; result and flags held stable until out_ready. On out_valid & out_ready go to IDLE.
- Handshake:
  - in_ready is 0 in RUN and DONE.
  - A request cannot be accepted on the same edge as result retirement. Throughput is 1 request per WIDTH+2 cycles minimum.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge (32 for default).
- Flags, computed on the final RUN edge:
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
  - Both flags are forced to 0 for non-ADD/SUB opcodes.
  - zero is derived from the final result.
- SLT: the serial pass computes A-B. On the final edge, result = {WIDTH-1 zeros, sum_msb XOR ovf}; cout=0, overflow=0.
- Inputs src1/src2/ALU_control are ignored outside the accept edge. Changes during RUN do not affect the result.
- Reset, including mid-RUN or mid-DONE:
  - Immediately forces IDLE, in_ready=1, out_valid=0, result=0, zero=0, cout=0, overflow=0, cnt=0.
  - Any in-flight operation is discarded.
- Outputs are registered; no combinational path from in_* to out_*.

Decomposition:
- alu_pkg holds:
  - opcode constants: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND;
  - state encoding: IDLE, RUN, DONE;
  - the derived CNT_W.
- One sub-module, alu_bit_slice, is combinational:
  - inputs a, b, cin, op;
  - outputs r, cout;
  - does the invert-B and logic/adder select.
- alu_serial holds the FSM, counter, shift registers and flag logic.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, {zero,cout,overflow}=001, out_valid exactly 32 cycles after accept.
2. SUB 0x00000005 - 0x00000005 -> result 0x00000000, ZCV=110; SUB 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ZCV=011.
3. SLT 0xFFFFFFFF vs 0x00000001 -> 0x00000001, ZCV=000; SLT 0x00000001 vs 0xFFFFFFFF -> 0x00000000, ZCV=100; NOR 0,0 -> 0xFFFFFFFF, ZCV=000; AND 0xF0F0F0F0, 0x0F0F0F0F -> 0, ZCV=100; opcode 1111 -> 0, ZCV=100.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, result and flags stable, in_ready=0; raise out_ready -> in_ready=1 the next cycle. Toggle src1 during RUN -> result unchanged.
5. Assert rst at cnt=15 of an ADD -> out_valid=0 and in_ready=1 without waiting for a clock edge. Release rst and issue ADD 1+1 -> 0x00000002, ZCV=000.
6. Back-to-back: in_valid held high with 30 queued patterns -> each accepted only in IDLE, all results match the reference model, no request dropped or duplicated.
